// File: rtl/xe11_dma_pkg.sv
// Shared definitions for the DEUNA Unibus DMA sequencer: FSM encodings,
// Unibus control codes and the ARM-visible ident word.
package xe11_dma_pkg;

    typedef logic [2:0] dma_state_t;

    localparam dma_state_t ST_IDLE  = 3'd0;
    localparam dma_state_t ST_REQ   = 3'd1;
    localparam dma_state_t ST_SETUP = 3'd2;
    localparam dma_state_t ST_MSYN  = 3'd3;
    localparam dma_state_t ST_UNSYN = 3'd4;
    localparam dma_state_t ST_NEXT  = 3'd5;
    localparam dma_state_t ST_DONE  = 3'd6;
    localparam dma_state_t ST_ABORT = 3'd7;

    localparam logic [1:0] C_DATI = 2'b00;
    localparam logic [1:0] C_DATO = 2'b10;

    localparam logic [31:0] XE11_IDENT = 32'h58441002;

    // Unibus word addresses step by two and wrap within the 18-bit space.
    function automatic logic [17:0] next_word(input logic [17:0] a);
        return a + 18'd2;
    endfunction

endpackage

// File: rtl/xe11_dma_if.sv
// ARM register port plus Unibus NPR master signals of the DMA sequencer.
interface xe11_dma_if;
    import xe11_dma_pkg::*;

    // Handshakes: dmareq is held high for the whole burst and dmagnt stays high
    // until dmareq drops. A bus cycle is MSYN high until SSYN is seen high, then
    // MSYN low until SSYN is seen low; a/c/d are stable from DESKEW cycles before
    // MSYN rises until SSYN has dropped. ARM writes are single-cycle strobes.
    logic        armwrite;
    logic [1:0]  armraddr;
    logic [1:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic        armintrq;
    logic        dmareq;
    logic        dmagnt;
    logic        init_in_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h;
    logic [15:0] d_in_h;
    logic        ssyn_in_h;
    dma_state_t  state_dbg;

    modport master (
        input  armwrite, armraddr, armwaddr, armwdata, dmagnt, init_in_h, d_in_h, ssyn_in_h,
        output armrdata, armintrq, dmareq, a_out_h, c_out_h, d_out_h, msyn_out_h, state_dbg
    );

    modport slave (
        output armwrite, armraddr, armwaddr, armwdata, dmagnt, init_in_h, d_in_h, ssyn_in_h,
        input  armrdata, armintrq, dmareq, a_out_h, c_out_h, d_out_h, msyn_out_h, state_dbg
    );

endinterface

// File: rtl/xe11_dmabuf.sv
// 16x16 word buffer: ARM port and bus port, synchronous write, combinational read.
module xe11_dmabuf (
    input  logic        CLOCK,
    input  logic        a_we,
    input  logic [3:0]  a_waddr,
    input  logic [15:0] a_wdata,
    input  logic [3:0]  a_raddr,
    output logic [15:0] a_rdata,
    input  logic        b_we,
    input  logic [3:0]  b_addr,
    input  logic [15:0] b_wdata,
    output logic [15:0] b_rdata
);

    logic [15:0] mem [16];

    // The ARM port is only enabled while idle, so the two writes never collide.
    always_ff @(posedge CLOCK) begin
        if (a_we) mem[a_waddr] <= a_wdata;
        if (b_we) mem[b_addr]  <= b_wdata;
    end

    assign a_rdata = mem[a_raddr];
    assign b_rdata = mem[b_addr];

endmodule

// File: rtl/xe11_dma.sv
// Unibus NPR DMA sequencer: ARM-queued bursts of up to 16 DATI/DATO cycles
// with deskew, SSYN timeout, abort/INIT handling and a done interrupt.
module xe11_dma
    import xe11_dma_pkg::*;
#(
    parameter int DESKEW  = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    xe11_dma_if.master  bus
);

    localparam logic [9:0] DESKEW_LD  = 10'(DESKEW - 1);
    localparam logic [9:0] TIMEOUT_LD = 10'(TIMEOUT - 1);

    dma_state_t  state;
    logic [9:0]  cnt;
    logic        busy, err, done, dir;
    logic [3:0]  remaining, wptr, rdidx;
    logic [17:0] curaddr, startaddr;
    logic [15:0] arm_rdata, bus_rdata;

    logic go_wr, buf_wr, ctl_wr, kill, dati_cap, drive;

    assign go_wr  = bus.armwrite && (bus.armwaddr == 2'd1) && bus.armwdata[31];
    assign buf_wr = bus.armwrite && (bus.armwaddr == 2'd2);
    assign ctl_wr = bus.armwrite && (bus.armwaddr == 2'd3);

    // INIT or ARM abort pulls the sequencer out of any active state.
    assign kill = (state != ST_IDLE) && (state != ST_ABORT) &&
                  (bus.init_in_h || (ctl_wr && bus.armwdata[31]));

    assign dati_cap = (state == ST_MSYN) && bus.ssyn_in_h && !dir && !kill;

    xe11_dmabuf u_buf (
        .CLOCK   (CLOCK),
        .a_we    (buf_wr && !busy),
        .a_waddr (bus.armwdata[19:16]),
        .a_wdata (bus.armwdata[15:0]),
        .a_raddr (rdidx),
        .a_rdata (arm_rdata),
        .b_we    (dati_cap),
        .b_addr  (wptr),
        .b_wdata (bus.d_in_h),
        .b_rdata (bus_rdata)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            dir       <= 1'b0;
            remaining <= '0;
            wptr      <= '0;
            rdidx     <= '0;
            curaddr   <= '0;
            startaddr <= '0;
        end else begin
            if (buf_wr) rdidx <= bus.armwdata[19:16];
            if (ctl_wr && bus.armwdata[30]) done <= 1'b0;
            if (kill) begin
                state <= ST_ABORT;
                cnt   <= TIMEOUT_LD;
            end else begin
                case (state)
                    ST_IDLE: if (go_wr) begin
                        dir       <= bus.armwdata[30];
                        remaining <= bus.armwdata[23:20];
                        curaddr   <= {bus.armwdata[17:1], 1'b0};
                        startaddr <= {bus.armwdata[17:1], 1'b0};
                        wptr      <= '0;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        done      <= 1'b0;
                        state     <= ST_REQ;
                    end
                    ST_REQ: if (bus.dmagnt) begin
                        cnt   <= DESKEW_LD;
                        state <= ST_SETUP;
                    end
                    ST_SETUP: if (cnt == '0) begin
                        cnt   <= TIMEOUT_LD;
                        state <= ST_MSYN;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                    ST_MSYN: if (bus.ssyn_in_h) begin
                        state <= ST_UNSYN;
                    end else if (cnt == '0) begin
                        err   <= 1'b1;
                        state <= ST_UNSYN;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                    ST_UNSYN: if (!bus.ssyn_in_h) state <= ST_NEXT;
                    ST_NEXT: if (err || (remaining == '0)) begin
                        state <= ST_DONE;
                    end else begin
                        curaddr   <= next_word(curaddr);
                        wptr      <= wptr + 4'd1;
                        remaining <= remaining - 4'd1;
                        cnt       <= DESKEW_LD;
                        state     <= ST_SETUP;
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    ST_ABORT: if (!bus.ssyn_in_h || (cnt == '0)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Address/control/data are driven from SETUP through UNSYN only.
    assign drive = (state == ST_SETUP) || (state == ST_MSYN) || (state == ST_UNSYN);

    always_comb begin
        bus.a_out_h    = drive ? curaddr : 18'd0;
        bus.c_out_h    = drive ? (dir ? C_DATO : C_DATI) : 2'b00;
        bus.d_out_h    = (drive && dir) ? bus_rdata : 16'd0;
        bus.msyn_out_h = (state == ST_MSYN);
        bus.dmareq     = (state == ST_REQ) || drive || (state == ST_NEXT);
        bus.armintrq   = done;
        bus.state_dbg  = state;
        case (bus.armraddr)
            2'd0:    bus.armrdata = XE11_IDENT;
            2'd1:    bus.armrdata = {busy, err, dir, done, 4'b0, remaining, 2'b0, curaddr};
            2'd2:    bus.armrdata = {12'b0, rdidx, arm_rdata};
            default: bus.armrdata = {14'b0, startaddr};
        endcase
    end

endmodule
